// File: rtl/uart_pkg.sv
// Shared UART definitions: default line timing and the receive FSM encoding,
// used by both the receive and transmit sides.
package uart_pkg;

  localparam int unsigned CLK_F_DEF    = 50_000_000;
  localparam int unsigned UART_BPS_DEF = 115200;
  localparam int unsigned CLK_GOAL_DEF = CLK_F_DEF / UART_BPS_DEF;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: line synchronizer, start/data/stop bit FSM and the
// assembled byte with accept/reject pulses on the stop-bit sample cycle.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_GOAL = CLK_GOAL_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rxd,
  output logic [7:0] o_byte,
  output logic       o_byte_ok,
  output logic       o_byte_err,
  output logic       o_idle
);

  // state    | meaning
  // RX_IDLE  | line idle, waiting for a synchronized high-to-low edge
  // RX_START | timing to the start-bit mid-point to reject false starts
  // RX_DATA  | sampling 8 data bits, LSB first, one bit-time apart
  // RX_STOP  | sampling the stop bit; result reported in the same cycle

  localparam int unsigned   CW   = cnt_width(CLK_GOAL - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_GOAL / 2);
  localparam logic [CW-1:0] LAST = CW'(CLK_GOAL - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          r_sync1, r_sync2, r_rxd_d;
  rx_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_fall;

  assign w_fall = r_rxd_d & ~r_sync2;
  assign o_byte = r_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rxd_d   <= 1'b1;
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_sync1   <= i_rxd;
      r_sync2   <= r_sync1;
      r_rxd_d   <= r_sync2;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + ONE;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    o_byte_ok     = 1'b0;
    o_byte_err    = 1'b0;
    o_idle        = 1'b0;
    case (r_state)
      RX_IDLE: begin
        o_idle    = 1'b1;
        w_cnt_nxt = '0;
        if (w_fall) w_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_cnt == HALF) begin
          w_cnt_nxt = '0;
          if (!r_sync2) begin
            w_state_nxt   = RX_DATA;
            w_bit_idx_nxt = '0;
          end else begin
            w_state_nxt = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {r_sync2, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        // Return to idle on the sample itself so a start bit right after
        // the stop-bit mid-point is never missed.
        if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RX_IDLE;
          if (r_sync2) o_byte_ok  = 1'b1;
          else         o_byte_err = 1'b1;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/uart_rx_64.sv
// 64-bit word receiver: collects eight UART bytes (first byte most
// significant) and discards a partial word on a framing error or idle gap.
module uart_rx_64
  import uart_pkg::*;
#(
  parameter int unsigned CLK_F    = CLK_F_DEF,
  parameter int unsigned UART_BPS = UART_BPS_DEF,
  parameter int unsigned CLK_GOAL = CLK_F / UART_BPS,
  parameter int unsigned GAP_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  output logic [63:0] data_64,
  output logic        data_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned   GAP_LIMIT = GAP_BITS * CLK_GOAL;
  localparam int unsigned   GW        = cnt_width(GAP_LIMIT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LIMIT - 1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);

  logic [7:0]    w_byte;
  logic          w_byte_ok, w_byte_err, w_idle;
  logic          w_timeout;
  logic [55:0]   r_word;
  logic [2:0]    r_byte_idx;
  logic [GW-1:0] r_gap;
  logic [63:0]   r_data_64;
  logic          r_data_valid, r_frame_err;

  uart_rx_byte #(
    .CLK_GOAL (CLK_GOAL)
  ) u_rx_byte (
    .clk        (clk),
    .rst        (rst),
    .i_rxd      (uart_rxd),
    .o_byte     (w_byte),
    .o_byte_ok  (w_byte_ok),
    .o_byte_err (w_byte_err),
    .o_idle     (w_idle)
  );

  // Fires on the last allowed idle cycle so the pulse lands one cycle later.
  assign w_timeout = w_idle && (r_byte_idx != 3'd0) && (r_gap == GAP_LAST);

  assign data_64    = r_data_64;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = !w_idle || (r_byte_idx != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word       <= '0;
      r_byte_idx   <= '0;
      r_gap        <= '0;
      r_data_64    <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_byte_err || w_timeout) begin
        r_frame_err <= 1'b1;
        r_byte_idx  <= '0;
        r_word      <= '0;
      end else if (w_byte_ok) begin
        if (r_byte_idx == 3'd7) begin
          r_data_64    <= {r_word, w_byte};
          r_data_valid <= 1'b1;
          r_word       <= '0;
        end else begin
          r_word <= {r_word[47:0], w_byte};
        end
        r_byte_idx <= r_byte_idx + 3'd1;
      end

      if (w_idle && (r_byte_idx != 3'd0) && !w_timeout) r_gap <= r_gap + GAP_ONE;
      else                                              r_gap <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_64.sv
// Directed bench for uart_rx_64 with a word scoreboard; runs at a reduced
// clock (128 cycles per bit) so every scenario fits a short run.
module tb_uart_rx_64;

  localparam int unsigned TB_CLK_F = 14_745_600;
  localparam int unsigned TB_BPS   = 115200;
  localparam int          BIT      = TB_CLK_F / TB_BPS;
  localparam int          GAP      = 16;
  localparam int          GLITCH   = 30;   // ~100/434 of a bit, well under half a bit

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [63:0] data_64;
  logic        dv, fe, busy;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          dv_cnt = 0;
  int          fe_cnt = 0;
  int          dv_cyc = 0;
  int          fe_cyc = 0;
  int          stop_cyc = 0;
  int          dv_save, fe_save;
  logic [63:0] exp_q[$];

  localparam logic [63:0] W1 = 64'h2CFF0AEF8AE16865;
  localparam logic [63:0] W2 = 64'hE429F657A7C2DB78;
  localparam logic [63:0] W3 = 64'h0123456789ABCDEF;
  localparam logic [63:0] W4 = 64'hFEDCBA9876543210;

  uart_rx_64 #(
    .CLK_F    (TB_CLK_F),
    .UART_BPS (TB_BPS),
    .GAP_BITS (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rxd   (rxd),
    .data_64    (data_64),
    .data_valid (dv),
    .frame_err  (fe),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d..%0d", tag, obs, lo, hi);
  endtask

  // Pulse monitor: pops the scoreboard on every data_valid.
  always @(negedge clk) begin
    if (dv || fe) check("dv_fe_overlap", 64'(dv & fe), 64'd0);
    if (dv) begin
      dv_cnt++;
      dv_cyc = cyc;
      n_checks++;
      assert (exp_q.size() > 0) n_pass++;
      else $error("FAIL scoreboard_empty: got word %h, expected no data_valid", data_64);
      if (exp_q.size() > 0) check("word", data_64, exp_q.pop_front());
    end
    if (fe) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    rxd = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(BIT);
    end
    stop_cyc = cyc;
    rxd = stop_v;
    wait_cyc(BIT);
    rxd = 1'b1;
  endtask

  task automatic send_word(input logic [63:0] w);
    exp_q.push_back(w);
    for (int i = 7; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  initial begin
    logic [7:0] part;
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(3);
    check("rst_data", data_64, 64'h0);
    check("rst_dv", 64'(dv), 64'd0);
    check("rst_fe", 64'(fe), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    wait_cyc(BIT);

    // First word, back to back
    send_word(W1);
    wait_cyc(4);
    check("w1_dv_cnt", 64'(dv_cnt), 64'd1);
    check("w1_fe_cnt", 64'(fe_cnt), 64'd0);
    check("w1_data", data_64, W1);
    check("w1_busy", 64'(busy), 64'd0);
    check_range("w1_latency", dv_cyc - stop_cyc, BIT/2, BIT/2 + 6);

    // Second word; first value must be held while it is assembled
    exp_q.push_back(W2);
    for (int i = 7; i >= 1; i--) send_byte(W2[i*8 +: 8], 1'b1);
    check("w2_hold_data", data_64, W1);
    check("w2_hold_dv_cnt", 64'(dv_cnt), 64'd1);
    check("w2_mid_busy", 64'(busy), 64'd1);
    send_byte(W2[7:0], 1'b1);
    wait_cyc(4);
    check("w2_dv_cnt", 64'(dv_cnt), 64'd2);
    check("w2_data", data_64, W2);
    check("w2_fe_cnt", 64'(fe_cnt), 64'd0);

    // Short low glitch on an idle line
    rxd = 1'b0;
    wait_cyc(10);
    check("glitch_busy_high", 64'(busy), 64'd1);
    wait_cyc(GLITCH - 10);
    rxd = 1'b1;
    wait_cyc(2 * BIT);
    check("glitch_busy", 64'(busy), 64'd0);
    check("glitch_dv_cnt", 64'(dv_cnt), 64'd2);
    check("glitch_fe_cnt", 64'(fe_cnt), 64'd0);
    check("glitch_data", data_64, W2);

    // Bad stop bit on byte 3
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b0);
    wait_cyc(4);
    check("stop_fe_cnt", 64'(fe_cnt), 64'd1);
    check("stop_dv_cnt", 64'(dv_cnt), 64'd2);
    check("stop_data", data_64, W2);
    check("stop_busy", 64'(busy), 64'd0);
    wait_cyc(BIT);
    send_word(W3);
    wait_cyc(4);
    check("w3_dv_cnt", 64'(dv_cnt), 64'd3);
    check("w3_fe_cnt", 64'(fe_cnt), 64'd1);

    // Four bytes then a long idle gap
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hD4, 1'b1);
    check("gap_busy_early", 64'(busy), 64'd1);
    wait_cyc(19 * BIT);
    check("gap_fe_cnt", 64'(fe_cnt), 64'd2);
    check_range("gap_fe_time", fe_cyc - stop_cyc, BIT/2 + GAP*BIT, BIT/2 + GAP*BIT + 6);
    check("gap_busy", 64'(busy), 64'd0);
    check("gap_dv_cnt", 64'(dv_cnt), 64'd3);
    check("gap_data", data_64, W3);

    // Reset in the middle of byte 5
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    part = 8'h96;
    rxd = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 3; i++) begin
      rxd = part[i];
      wait_cyc(BIT);
    end
    dv_save = dv_cnt;
    fe_save = fe_cnt;
    rst = 1'b1;
    wait_cyc(1);
    check("mid_rst_data", data_64, 64'h0);
    check("mid_rst_dv", 64'(dv), 64'd0);
    check("mid_rst_fe", 64'(fe), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    rxd = 1'b1;
    wait_cyc(2 * BIT);
    check("post_rst_dv_cnt", 64'(dv_cnt), 64'(dv_save));
    check("post_rst_fe_cnt", 64'(fe_cnt), 64'(fe_save));
    send_word(W4);
    wait_cyc(4);
    check("w4_dv_cnt", 64'(dv_cnt), 64'(dv_save + 1));
    check("w4_data", data_64, W4);
    check("w4_fe_cnt", 64'(fe_cnt), 64'(fe_save));
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_64.md
UART_RX_64 -- requirements
Module: uart_rx_64

Interface
REQ-001 Parameter CLK_F, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, line baud rate.
REQ-003 Parameter CLK_GOAL, default CLK_F / UART_BPS (434), clock cycles per bit.
REQ-004 Parameter GAP_BITS, default 16, maximum idle bit-times allowed between bytes of one word.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 uart_rxd  input  1  asynchronous serial line; idle high; 8N1 framing; LSB first.
REQ-008 data_64  output  64  last complete received word; held until the next complete word.
REQ-009 data_valid  output  1  one-cycle pulse; data_64 is new this cycle.
REQ-010 frame_err  output  1  one-cycle pulse on a bad stop bit or an inter-byte timeout.
REQ-011 busy  output  1  high from start-bit detection of byte 0 until the word completes or is discarded.

Function
REQ-012 uart_rxd SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-013 Byte FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized high-to-low transition.
REQ-014 START: at count CLK_GOAL/2 (217), sample the line.
- Low -> DATA, bit counter cleared.
- High -> IDLE as a false start; no error pulse; word state unchanged.
REQ-015 DATA: sample every CLK_GOAL cycles from the START mid-point; shift in LSB first; -> STOP after 8 samples.
REQ-016 STOP: sample one bit-time later, then -> IDLE in the same cycle, so the next start edge can be detected immediately.
- High: byte accepted.
- Low: byte discarded, frame_err pulses, partial word cleared.
REQ-017 Word assembly: byte 0 is the most significant, so the first byte lands in data_64[63:56] and the eighth in [7:0].
REQ-018 When the eighth byte is accepted, data_64 SHALL update and data_valid SHALL pulse on the cycle after the stop-bit sample (latency 1).
- busy falls in that same cycle.
- Byte index wraps to 0.
REQ-019 Timeout: byte index 1..7 with the FSM in IDLE for more than GAP_BITS*CLK_GOAL cycles -> discard partial word, pulse frame_err, byte index 0, busy low.
REQ-020 data_64 SHALL never change on an error or a partial word; only a complete word updates it.
REQ-021 data_valid and frame_err SHALL never assert in the same cycle.
REQ-022 The bit-period counter SHALL be wide enough for CLK_GOAL-1 and SHALL reload to 0 on every sample point.
REQ-023 A line held low (break) SHALL produce one frame_err at the STOP sample; the FSM then waits in IDLE for a fresh high-to-low edge.

Reset
REQ-024 rst SHALL clear, on the next clock edge:
- FSM to IDLE.
- Counters and byte index to 0.
- data_64 to 64'h0; data_valid, frame_err and busy to 0.
- Synchronizer flops to 1 (idle line).
REQ-025 rst asserted mid-byte or mid-word SHALL abort the reception with no pulse; the first start edge after release begins byte 0.

Structure
REQ-026 Shared package uart_pkg SHALL hold CLK_F, UART_BPS and CLK_GOAL defaults and the rx FSM state encoding, shared with the transmit side.
REQ-027 One sub-module, uart_rx_byte, SHALL contain the synchronizer, the bit FSM and the byte output.
- Outputs: byte, byte_ok pulse, byte_err pulse, idle.
- The top level holds the word assembly and the timeout.

Verification
REQ-028 Send bytes 2C FF 0A EF 8A E1 68 65 back-to-back at 115200 -> data_64 = 64'h2CFF0AEF8AE16865, one data_valid pulse ~1 cycle after the last stop-bit mid-point, frame_err never high.
REQ-029 Send 64'hE429F657A7C2DB78 immediately after the scenario in REQ-028 -> second data_valid with that value; the first value is held until then.
REQ-030 Low glitch of 100 cycles on idle line -> no state change, busy returns low, no pulses.
REQ-031 Byte 3 sent with stop bit = 0 -> one frame_err, data_64 unchanged, next full 8-byte word received correctly.
REQ-032 Send 4 bytes, then idle 20 bit-times -> frame_err once at 16 bit-times + 1 cycle, busy low, no data_valid.
REQ-033 rst pulsed during byte 5 -> all outputs 0 next cycle; a new full word afterwards is received correctly.
